// File: rtl/tog_sync_sched.sv
// Round-robin source-side scheduler feeding the toggle-synchronizer data channel (clock domain A).
// Optional ack handshake on HOLD exit enabled by defining TSYNC_SCHED_ACK_EN.
module tog_sync_sched #(
    parameter int unsigned N           = 8,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    localparam int unsigned SW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clkA,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*N-1:0]   req_data,
`ifdef TSYNC_SCHED_ACK_EN
    input  logic                 ack_tog,
    output logic                 err,
`endif
    output logic [N_REQ-1:0]     gnt,
    output logic [N-1:0]         data_out,
    output logic                 pulse_out,
    output logic                 busy,
    output logic [SW-1:0]        last_src
);

    localparam int unsigned CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StHold
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] ptr_q;     // first index scanned in the next arbitration
`ifdef TSYNC_SCHED_ACK_EN
    logic          exp_q;
`endif

    logic          win_found;
    logic [SW-1:0] win_idx;
    int unsigned   j;

    // Scan upward from the pointer, wrapping modulo N_REQ; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr_q) + i) % N_REQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = SW'(j);
            end
        end
    end

    always_ff @(posedge clkA) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt       <= '0;
            data_out  <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            last_src  <= '0;
`ifdef TSYNC_SCHED_ACK_EN
            exp_q     <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (ena && win_found) begin
                        data_out  <= req_data[win_idx*N +: N];
                        gnt       <= N_REQ'(1) << win_idx;
                        pulse_out <= 1'b1;
                        busy      <= 1'b1;
                        last_src  <= win_idx;
                        ptr_q     <= (win_idx == SW'(N_REQ - 1)) ? '0 : win_idx + SW'(1);
                        state_q   <= StLaunch;
                    end
                end
                StLaunch: begin
                    gnt       <= '0;
                    pulse_out <= 1'b0;
                    cnt_q     <= CW'(HOLD_CYCLES - 1);
`ifdef TSYNC_SCHED_ACK_EN
                    exp_q     <= ~ack_tog;
`endif
                    state_q   <= StHold;
                end
                StHold: begin
`ifdef TSYNC_SCHED_ACK_EN
                    // An ack on the timeout edge still counts as success.
                    if (ack_tog == exp_q) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
`else
                    if (cnt_q == '0) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
`endif
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tog_sync_sched.sv
// Directed self-checking bench for tog_sync_sched (N=8, N_REQ=4, HOLD_CYCLES=8).
// Ack-path vectors are compiled in when TSYNC_SCHED_ACK_EN is defined.
module tb_tog_sync_sched;

    logic        clkA = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  data_out;
    logic        pulse_out;
    logic        busy;
    logic [1:0]  last_src;
    logic        ack_tog;
`ifdef TSYNC_SCHED_ACK_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tog_sync_sched #(
        .N           (8),
        .N_REQ       (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clkA      (clkA),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .req_data  (req_data),
`ifdef TSYNC_SCHED_ACK_EN
        .ack_tog   (ack_tog),
        .err       (err),
`endif
        .gnt       (gnt),
        .data_out  (data_out),
        .pulse_out (pulse_out),
        .busy      (busy),
        .last_src  (last_src)
    );

    always #5 clkA = ~clkA;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkA);
        #1;
    endtask

    int          npulse;
    int          pcyc[$];
    logic [3:0]  pg[$];
    logic [7:0]  pd[$];
    logic [3:0]  rr_gnt [5];
    logic [7:0]  rr_dat [5];

    initial begin
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dat = '{8'hB0, 8'hA5, 8'hC2, 8'hD3, 8'hB0};
        rst = 1'b1; ena = 1'b0; req = '0; ack_tog = 1'b0;
        req_data = {8'hD3, 8'hC2, 8'hA5, 8'hB0};

        // Reset then idle
        repeat (3) tick();
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_pulse", 32'(pulse_out), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_data", 32'(data_out), 32'h0);
        check_val("rst_last", 32'(last_src), 32'h0);
        rst = 1'b0; ena = 1'b1;
        npulse = 0;
        repeat (20) begin tick(); if (pulse_out) npulse++; end
        check_val("idle_no_pulse", 32'(npulse), 32'h0);

        // Single transfer from requester 1
        req = 4'b0010;
        tick();
        check_val("single_pulse", 32'(pulse_out), 32'h1);
        check_val("single_gnt", 32'(gnt), 32'h2);
        check_val("single_data", 32'(data_out), 32'hA5);
        check_val("single_last", 32'(last_src), 32'h1);
        req = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_val($sformatf("hold_data_%0d", c), 32'(data_out), 32'hA5);
            check_val($sformatf("hold_busy_%0d", c), 32'(busy), 32'h1);
            check_val($sformatf("hold_nopulse_%0d", c), 32'(pulse_out), 32'h0);
        end
        tick();
        check_val("single_busy_fall", 32'(busy), 32'h0);

        // Round-robin after a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (pulse_out) begin
                pcyc.push_back(c); pg.push_back(gnt); pd.push_back(data_out);
                if (pg.size() == 5) req = '0;
            end
        end
        repeat (6) tick();
        check_val("rr_count", 32'(pcyc.size()), 32'd5);
        for (int i = 0; i < pg.size() && i < 5; i++) begin
            check_val($sformatf("rr_gnt_%0d", i), 32'(pg[i]), 32'(rr_gnt[i]));
            check_val($sformatf("rr_data_%0d", i), 32'(pd[i]), 32'(rr_dat[i]));
            if (i > 0) check_val($sformatf("rr_space_%0d", i), 32'(pcyc[i] - pcyc[i-1]), 32'd10);
        end
        check_val("rr_idle", 32'(busy), 32'h0);

        // ena gating
        ena = 1'b0; req = 4'b0100;
        npulse = 0;
        repeat (30) begin tick(); if (pulse_out) npulse++; end
        check_val("ena_block", 32'(npulse), 32'h0);
        ena = 1'b1;
        tick();
        check_val("ena_pulse", 32'(pulse_out), 32'h1);
        check_val("ena_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
        ena = 1'b0;
        repeat (7) tick();
        check_val("ena_drop_busy", 32'(busy), 32'h1);
        tick();
        check_val("ena_drop_fall", 32'(busy), 32'h0);

        // Reset mid-HOLD
        ena = 1'b1; req = 4'b1000;
        tick();
        check_val("mid_gnt", 32'(gnt), 32'h8);
        req = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_val("mid_rst_data", 32'(data_out), 32'h0);
        check_val("mid_rst_busy", 32'(busy), 32'h0);
        check_val("mid_rst_last", 32'(last_src), 32'h0);
        rst = 1'b0; req = 4'b1001;
        tick();
        check_val("post_rst_gnt", 32'(gnt), 32'h1);
        check_val("post_rst_data", 32'(data_out), 32'hB0);
        repeat (10) tick();
        check_val("post_rst_gnt2", 32'(gnt), 32'h8);
        check_val("post_rst_pulse2", 32'(pulse_out), 32'h1);
        req = '0;
        repeat (10) tick();

`ifdef TSYNC_SCHED_ACK_EN
        rst = 1'b1; tick(); rst = 1'b0;
        check_val("ack_rst_err", 32'(err), 32'h0);
        req = 4'b0001;
        tick();
        req = '0;
        repeat (3) tick();
        ack_tog = 1'b1;
        tick();
        check_val("ack_early_busy", 32'(busy), 32'h0);
        check_val("ack_early_err", 32'(err), 32'h0);
        req = 4'b0010;
        tick();
        req = '0;
        repeat (8) tick();
        check_val("ack_to_busy", 32'(busy), 32'h1);
        tick();
        check_val("ack_to_fall", 32'(busy), 32'h0);
        check_val("ack_to_err", 32'(err), 32'h1);
        repeat (5) tick();
        check_val("ack_err_sticky", 32'(err), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_val("ack_err_clr", 32'(err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tog_sync_sched.md
Name: tog_sync_sched

Overview:
- Source-side scheduler in clock domain A for the toggle-synchronizer data channel.
- Arbitrates N_REQ requesters round-robin onto the single channel and drives the channel's data and pulse inputs.
- Holds launched data stable for a guard interval so the domain-B capture is never corrupted.
- Sits between clkA requesters and the synchronizer's data_in/pulse_in pins.

Parameters:
- N, 8, data width per transfer (matches synchronizer N).
- N_REQ, 4, number of requesters (2..16).
- HOLD_CYCLES, 8, clkA cycles data is held after launch. Minimum 1. With ack enabled, this is the ack timeout.

Ports:
- clkA  in  1  clock (domain A).
- rst  in  1  synchronous reset, active-high.
- ena  in  1  high = new arbitrations allowed.
- req  in  N_REQ  per-requester transfer request, level.
- req_data  in  N_REQ*N  flattened data; requester i owns bits [i*N +: N].
- gnt  out  N_REQ  one-hot, one-cycle grant; requester may drop req after it.
- data_out  out  N  to synchronizer data_in; stable from LAUNCH through end of HOLD.
- pulse_out  out  1  to synchronizer pulse_in; one-cycle pulse per transfer.
- busy  out  1  high in LAUNCH or HOLD.
- last_src  out  max(1,$clog2(N_REQ))  index of the most recent grant.

Behaviour:
- Clock and reset are decided: one clock, clkA; reset is synchronous and active-high, port rst.
- All state and outputs are registered. On rst: state=IDLE, gnt=0, pulse_out=0, busy=0, data_out=0, last_src=0, hold counter=0, RR pointer=0 (requester 0 highest priority).
- IDLE:
  - If ena && |req at an edge: winner = first set req scanning upward from (last_src+1) mod N_REQ. After reset the scan starts at 0.
  - At that same edge: data_out<=winner's req_data, gnt[winner]<=1, pulse_out<=1, last_src<=winner, state<=LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: exactly one cycle. gnt and pulse_out are high during it. Next edge: gnt<=0, pulse_out<=0, counter<=HOLD_CYCLES-1, state<=HOLD.
- HOLD:
  - data_out frozen; req and ena ignored.
  - Counter decrements each cycle; at the edge where counter==0, state<=IDLE.
  - HOLD lasts exactly HOLD_CYCLES cycles.
- Latency:
  - pulse_out rises the cycle after req is sampled.
  - Minimum pulse-to-pulse spacing is HOLD_CYCLES+2 cycles: LAUNCH + HOLD + one IDLE arbitration cycle.
- ena low:
  - Blocks new arbitration only; an in-flight LAUNCH/HOLD always completes.
  - ena rising with req pending arbitrates on that edge.
- Simultaneous requests: one winner only; losers keep req high and win in later rounds in RR order.
- A requester dropping req before grant is simply not considered.
- Any req pattern with a single requester is granted every round (no starvation, no lockout).
- busy = (state != IDLE).
- Reset asserted mid-LAUNCH/HOLD aborts immediately to reset values. The dropped transfer is not replayed.
- Counter width: $clog2(HOLD_CYCLES+1).

Optional Feature:
- Macro TSYNC_SCHED_ACK_EN.
- When defined:
  - Adds input ack_tog (1 bit): destination-side toggle already synchronized into clkA by the caller.
  - Adds output err (1 bit, reset 0).
  - In LAUNCH, the expected value is registered as ~ack_tog.
  - HOLD exits at the first edge where ack_tog equals the expected value.
  - If the counter reaches 0 first (HOLD_CYCLES cycles), HOLD exits and err<=1 (sticky, cleared only by rst).
  - Early ack exit still passes through one IDLE cycle before the next LAUNCH.
- When undefined: no ack_tog or err ports; HOLD is a pure fixed timer as above.

Test Plan:
- Reset then idle:
  - rst high 3 cycles, req=0 -> all outputs 0, busy=0, no pulse for 20 cycles.
- Single transfer:
  - req=4'b0010, req_data[15:8]=8'hA5 sampled at edge k -> cycle k+1: pulse_out=1, gnt=4'b0010, data_out=8'hA5.
  - data_out stays 8'hA5 for 8 further cycles; busy falls after cycle k+9.
- Round-robin:
  - req=4'b1111 held -> grant order 0,1,2,3,0.
  - Pulses spaced exactly 10 cycles apart with HOLD_CYCLES=8.
- ena gating:
  - ena=0 with req=4'b0100 -> no pulse for 30 cycles.
  - ena=1 -> pulse the next cycle with gnt=4'b0100.
  - ena dropped during HOLD -> transfer completes and busy falls on time.
- Reset mid-HOLD:
  - rst at 3rd HOLD cycle -> next cycle data_out=0, busy=0, last_src=0.
  - With req=4'b1001 pending after reset, requester 0 is granted first.
- Ack option (TSYNC_SCHED_ACK_EN):
  - ack_tog toggles 3 cycles after pulse -> HOLD exits early, err=0.
  - No toggle -> HOLD exits after 8 cycles, err=1 and stays 1 until rst.
